// File: rtl/implication_queue.sv
// Implication FIFO for the BCP datapath: buffers implied assignments, drops duplicates via a
// per-variable pending table, and raises a sticky conflict on opposing implications or a failed clause.
module implication_queue #(
    parameter int NUM_VARIABLE = 128,
    parameter int VAR_W        = $clog2(NUM_VARIABLE),
    parameter int DEPTH        = 16,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_unit,
    input  logic [VAR_W-1:0] in_var,
    input  logic             in_value,
    input  logic             in_clause_fail,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VAR_W-1:0] out_var,
    output logic             out_value,
    output logic [CNT_W-1:0] count,
    output logic             conflict,
    output logic             conflict_src,
    output logic [VAR_W-1:0] conflict_var
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [VAR_W-1:0]        mem_var [DEPTH];
    logic [DEPTH-1:0]        mem_value;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [NUM_VARIABLE-1:0] pend_valid;
    logic [NUM_VARIABLE-1:0] pend_value;

    logic             full;
    logic             empty;
    logic             accept;
    logic             do_pop;
    logic             do_push;
    logic             is_unit;
    logic             hit;
    logic             opposite;
    logic [VAR_W-1:0] head_var;

    always_comb begin
        full      = (count == CNT_W'(DEPTH));
        empty     = (count == '0);
        in_ready  = !full && !conflict && !flush;
        out_valid = !empty && !conflict && !flush;
        head_var  = mem_var[rd_ptr];
        // Head is forced to zero when empty so reset/flush leave a clean output.
        out_var   = empty ? '0 : head_var;
        out_value = empty ? 1'b0 : mem_value[rd_ptr];
        accept    = in_valid && in_ready;
        do_pop    = out_valid && out_ready;
        is_unit   = accept && !in_clause_fail && in_is_unit;
        hit       = pend_valid[in_var];
        do_push   = is_unit && !hit;
        opposite  = is_unit && hit && (pend_value[in_var] != in_value);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            pend_valid   <= '0;
            pend_value   <= '0;
            conflict     <= 1'b0;
            conflict_src <= 1'b0;
            conflict_var <= '0;
        end else begin
            if (accept && in_clause_fail) begin
                conflict     <= 1'b1;
                conflict_src <= 1'b1;
                conflict_var <= '0;
            end else if (opposite) begin
                conflict     <= 1'b1;
                conflict_src <= 1'b0;
                conflict_var <= in_var;
            end
            // A pushed var never equals the popped head var, so these pend updates never collide.
            if (do_pop) begin
                rd_ptr               <= rd_ptr + PTR_W'(1);
                pend_valid[head_var] <= 1'b0;
            end
            if (do_push) begin
                wr_ptr             <= wr_ptr + PTR_W'(1);
                pend_valid[in_var] <= 1'b1;
                pend_value[in_var] <= in_value;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_var[wr_ptr]   <= in_var;
            mem_value[wr_ptr] <= in_value;
        end
    end

endmodule
